ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 32, the data and address width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, the watchdog limit in clk cycles.
REQ-003 clk  in  1  single clock; all state SHALL change on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req0, req1  in  1 each  requester n asks for one memory access.
REQ-006 wr0, wr1  in  1 each  1 = write, 0 = read.
REQ-007 addr0, addr1, data0, data1  in  WORD_SIZE each  requester address and write data.
REQ-008 ack0, ack1  out  1 each  one-cycle completion pulse.
REQ-009 rdata0, rdata1  out  WORD_SIZE each  read result.
REQ-010 mem_addr, mem_data  out  WORD_SIZE each  to memory addr and data.
REQ-011 mem_wr  out  1  to memory wr.
REQ-012 mem_response  in  1  from memory response: low = busy, high = done.
REQ-013 mem_out  in  WORD_SIZE  from memory out.
REQ-014 err  out  1  one-cycle timeout pulse.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-016 Arbitration SHALL occur only in IDLE:
- single req: granted.
- both req: the port not granted last wins (round-robin); the pointer favours port 0 after reset.
REQ-017 On grant, the block SHALL register that port's wr, addr and data onto mem_wr, mem_addr and mem_data at the same edge.
REQ-018 mem_wr, mem_addr and mem_data SHALL hold their values between transactions and never return to zero, because any change starts a memory operation.
REQ-019 If the granted command equals the last issued command and a last-valid flag is set, the FSM SHALL go IDLE->DONE and take rdata from mem_out without waiting.
REQ-020 Otherwise the FSM SHALL go IDLE->ISSUE; ISSUE->WAIT when mem_response==0; WAIT->DONE when mem_response==1.
REQ-021 On the WAIT->DONE edge, a read SHALL capture mem_out into rdata of the granted port.
REQ-022 In DONE, ack of the granted port SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-023 rdataN SHALL hold its value until the next read completion on port N; writes SHALL NOT change rdata.
REQ-024 Requesters SHALL hold wr, addr and data stable from req high until ack; req still high after ack SHALL count as a new request.
REQ-025 A non-granted req SHALL wait, with no lost requests and no starvation under continuous contention.
REQ-026 Minimum latency SHALL be:
- grant to ack, non-repeated command: 3 cycles;
- grant to ack, repeated command: 1 cycle.

Reset
REQ-027 While rst_n is low, outputs SHALL be: ack0=ack1=0, err=0, rdata0=rdata1=0, mem_wr=0, mem_addr=0, mem_data=0.
REQ-028 While rst_n is low, state SHALL be IDLE, the round-robin pointer SHALL favour port 0, and last-valid SHALL be 0.
REQ-029 Reset mid-transaction SHALL abort it with no ack; the interrupted requester SHALL re-request.

Configuration
REQ-030 Macro RAM_ARB_TIMEOUT_EN SHALL select the watchdog.
REQ-031 When RAM_ARB_TIMEOUT_EN is defined:
- a counter SHALL count cycles spent in ISSUE or WAIT;
- on reaching TIMEOUT, err SHALL pulse one cycle, the FSM SHALL go to IDLE with no ack and no rdata update, and last-valid SHALL clear.
REQ-032 When RAM_ARB_TIMEOUT_EN is undefined, there SHALL be no counter, err SHALL be tied 0, and the FSM SHALL wait indefinitely.

Verification
REQ-033 Write then read: req0 write addr=5 data=0xDEADBEEF, then req0 read addr=5 -> ack0 after 3 cycles each; rdata0=0xDEADBEEF.
REQ-034 Contention: req0 and req1 high in the same cycle after reset -> port 0 acked first, then port 1; with both held high, acks alternate 0,1,0,1.
REQ-035 Repeat: two consecutive reads of addr=7 from port 1 -> the second ack1 comes 1 cycle after grant; mem_addr does not toggle; rdata1 is unchanged.
REQ-036 Reset mid-op: rst_n low while in WAIT -> no ack; mem_wr=0, mem_addr=0, mem_data=0 immediately; after release, a new request completes normally.
REQ-037 Timeout (RAM_ARB_TIMEOUT_EN defined, TIMEOUT=16): mem_response held 0 -> err pulses 16 cycles after grant, no ack; without the macro, no err and the FSM stays in WAIT.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-command memory interface.
// Latency: grant to ack 3 cycles for a new command, 1 cycle for a repeated command.
// Backpressure: a losing requester waits in IDLE; memory stalls hold the FSM in ISSUE/WAIT.
// Optional watchdog: define RAM_ARB_TIMEOUT_EN to abort ISSUE/WAIT after TIMEOUT cycles with an err pulse.
module ram_arbiter #(
   parameter int WORD_SIZE = 32,
   parameter int TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0,
   input  logic                 req1,
   input  logic                 wr0,
   input  logic                 wr1,
   input  logic [WORD_SIZE-1:0] addr0,
   input  logic [WORD_SIZE-1:0] addr1,
   input  logic [WORD_SIZE-1:0] data0,
   input  logic [WORD_SIZE-1:0] data1,
   output logic                 ack0,
   output logic                 ack1,
   output logic [WORD_SIZE-1:0] rdata0,
   output logic [WORD_SIZE-1:0] rdata1,
   output logic [WORD_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0] mem_data,
   output logic                 mem_wr,
   input  logic                 mem_response,
   input  logic [WORD_SIZE-1:0] mem_out,
   output logic                 err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                state, state_nx;
   logic                  gnt;        // port owning the current transaction
   logic                  ptr;        // port favoured on the next contended grant
   logic                  last_vld;   // mem_* hold a command the memory has completed
   logic                  any_req;
   logic                  sel;
   logic                  sel_wr;
   logic [WORD_SIZE-1:0]  sel_addr;
   logic [WORD_SIZE-1:0]  sel_data;
   logic                  repeat_hit;
   logic                  timeout_hit;
   logic                  grant;

   // Round-robin selection and the command of the selected port
   always_comb begin
      any_req  = req0 | req1;
      sel      = (req0 & req1) ? ptr : req1;
      sel_wr   = sel ? wr1   : wr0;
      sel_addr = sel ? addr1 : addr0;
      sel_data = sel ? data1 : data0;
      repeat_hit = last_vld && ({sel_wr, sel_addr, sel_data} == {mem_wr, mem_addr, mem_data});
      grant    = (state == IDLE) && any_req;
   end

`ifdef RAM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wd_cnt;

   // Watchdog: counts cycles spent waiting on memory, restarts on every other state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
         err    <= 1'b0;
      end else begin
         err <= timeout_hit;
         if ((state == ISSUE || state == WAIT) && !timeout_hit)
            wd_cnt <= wd_cnt + 1'b1;
         else
            wd_cnt <= '0;
      end
   end

   assign timeout_hit = (state == ISSUE || state == WAIT) && (wd_cnt == CNT_W'(TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic; a repeated command skips the memory handshake entirely
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (any_req) state_nx = repeat_hit ? DONE : ISSUE;
         ISSUE: if (timeout_hit) state_nx = IDLE;
                else if (!mem_response) state_nx = WAIT;
         WAIT:  if (timeout_hit) state_nx = IDLE;
                else if (mem_response) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Completion pulse goes to whichever port owns the transaction
   assign ack0 = (state == DONE) && !gnt;
   assign ack1 = (state == DONE) &&  gnt;

   // Datapath: command launch on grant, read capture on completion.
   // mem_* are only rewritten on grant because any change starts a memory operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt      <= 1'b0;
         ptr      <= 1'b0;
         last_vld <= 1'b0;
         mem_wr   <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
         rdata0   <= '0;
         rdata1   <= '0;
      end else begin
         if (grant) begin
            gnt      <= sel;
            ptr      <= ~sel;
            mem_wr   <= sel_wr;
            mem_addr <= sel_addr;
            mem_data <= sel_data;
            // Memory already holds this command's result on mem_out
            if (repeat_hit && !sel_wr) begin
               if (sel) rdata1 <= mem_out;
               else     rdata0 <= mem_out;
            end
         end
         if (timeout_hit) begin
            last_vld <= 1'b0;
         end else if (state == WAIT && mem_response) begin
            last_vld <= 1'b1;
            if (!mem_wr) begin
               if (gnt) rdata1 <= mem_out;
               else     rdata0 <= mem_out;
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural single-port memory.
// The memory reports busy for one cycle whenever its command inputs change.
// Expected read data comes from a shadow memory pushed into per-port queues.
module tb_ram_arbiter;

   localparam int WS = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
   logic [WS-1:0] addr0 = '0, addr1 = '0, data0 = '0, data1 = '0;
   logic          ack0, ack1, mem_wr, err, mem_response;
   logic [WS-1:0] rdata0, rdata1, mem_addr, mem_data, mem_out;

   always #5 clk = ~clk;

   ram_arbiter #(.WORD_SIZE(WS), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
      .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr),
      .mem_response(mem_response), .mem_out(mem_out), .err(err)
   );

   // Memory model: busy while the command differs from the one last absorbed
   logic [WS-1:0]   mem_arr [0:255];
   logic [2*WS:0]   seen = '0;
   logic            busy;
   logic            stall = 1'b0;
   int              chg_cnt = 0;

   assign busy         = ({mem_wr, mem_addr, mem_data} != seen);
   assign mem_response = !busy && !stall;
   assign mem_out      = mem_arr[mem_addr[7:0]];

   always @(posedge clk) begin
      seen <= {mem_wr, mem_addr, mem_data};
      if (busy) chg_cnt <= chg_cnt + 1;
      if (busy && mem_wr) mem_arr[mem_addr[7:0]] <= mem_data;
   end

   // Scoreboard
   logic [WS-1:0] shadow [0:255];
   logic [WS-1:0] exp_q0[$];
   logic [WS-1:0] exp_q1[$];
   logic [WS-1:0] got;
   int n_checks = 0;
   int n_pass   = 0;

   // Issue one request, wait for its ack, then release and let the FSM return to IDLE
   task automatic do_req(input bit port, input bit wr, input logic [WS-1:0] addr,
                         input logic [WS-1:0] data, output int cyc);
      bit done = 0;
      cyc = 0;
      if (wr) shadow[addr[7:0]] = data;
      else if (port) exp_q1.push_back(shadow[addr[7:0]]);
      else           exp_q0.push_back(shadow[addr[7:0]]);
      if (port) begin req1 = 1; wr1 = wr; addr1 = addr; data1 = data; end
      else      begin req0 = 1; wr0 = wr; addr0 = addr; data0 = data; end
      for (int i = 0; i < 100 && !done; i++) begin
         @(posedge clk); #1;
         cyc++;
         if ((port ? ack1 : ack0) === 1'b1) done = 1;
      end
      if (!done) cyc = -1;
      req0 = 0; req1 = 0;
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({ack0, ack1, err, mem_wr} !== 4'b0) $display("FAIL reset_ctl got=%b want=0000", {ack0, ack1, err, mem_wr});
      else n_pass++;
      n_checks++;
      if (rdata0 !== '0) $display("FAIL reset_rdata0 got=%h want=0", rdata0); else n_pass++;
      n_checks++;
      if (rdata1 !== '0) $display("FAIL reset_rdata1 got=%h want=0", rdata1); else n_pass++;
      n_checks++;
      if ({mem_addr, mem_data} !== '0) $display("FAIL reset_mem got=%h/%h want=0/0", mem_addr, mem_data);
      else n_pass++;
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      int c;
      do_req(0, 1, 32'd5, 32'hDEADBEEF, c);
      n_checks++;
      if (c !== 3) $display("FAIL wr_latency got=%0d want=3", c); else n_pass++;
      do_req(0, 0, 32'd5, 32'hDEADBEEF, c);
      n_checks++;
      if (c !== 3) $display("FAIL rd_latency got=%0d want=3", c); else n_pass++;
      got = exp_q0.pop_front();
      n_checks++;
      if (rdata0 !== got) $display("FAIL rd_data got=%h want=%h", rdata0, got); else n_pass++;
   endtask

   task automatic test_contention();
      bit order[$];
      bit both = 0;
      int c;
      pulse_reset();
      req0 = 1; wr0 = 1; addr0 = 32'd10; data0 = 32'hAAAA0000;
      req1 = 1; wr1 = 1; addr1 = 32'd11; data1 = 32'hBBBB1111;
      shadow[10] = 32'hAAAA0000;
      shadow[11] = 32'hBBBB1111;
      for (int i = 0; i < 60 && order.size() < 4; i++) begin
         @(posedge clk); #1;
         if (ack0 && ack1) both = 1;
         if (ack0) order.push_back(1'b0);
         if (ack1) order.push_back(1'b1);
      end
      req0 = 0; req1 = 0;
      @(posedge clk); #1;
      n_checks++;
      if (order.size() !== 4) $display("FAIL cont_count got=%0d want=4", order.size()); else n_pass++;
      for (int i = 0; i < 4 && i < order.size(); i++) begin
         n_checks++;
         if (order[i] !== 1'(i % 2)) $display("FAIL cont_order[%0d] got=%0d want=%0d", i, order[i], i % 2);
         else n_pass++;
      end
      n_checks++;
      if (both) $display("FAIL cont_dual_ack got=1 want=0"); else n_pass++;
      do_req(0, 0, 32'd11, 32'h0, c);
      got = exp_q0.pop_front();
      n_checks++;
      if (rdata0 !== got) $display("FAIL cont_rdata got=%h want=%h", rdata0, got); else n_pass++;
   endtask

   task automatic test_repeat();
      int c;
      int chg0;
      do_req(1, 1, 32'd7, 32'h12345678, c);
      do_req(1, 0, 32'd7, 32'h0, c);
      n_checks++;
      if (c !== 3) $display("FAIL rep_first_latency got=%0d want=3", c); else n_pass++;
      got = exp_q1.pop_front();
      n_checks++;
      if (rdata1 !== got) $display("FAIL rep_first_data got=%h want=%h", rdata1, got); else n_pass++;
      chg0 = chg_cnt;
      do_req(1, 0, 32'd7, 32'h0, c);
      n_checks++;
      if (c !== 1) $display("FAIL rep_latency got=%0d want=1", c); else n_pass++;
      got = exp_q1.pop_front();
      n_checks++;
      if (rdata1 !== got) $display("FAIL rep_data got=%h want=%h", rdata1, got); else n_pass++;
      n_checks++;
      if (chg_cnt !== chg0) $display("FAIL rep_mem_toggle got=%0d want=%0d", chg_cnt, chg0); else n_pass++;
      n_checks++;
      if (mem_addr !== 32'd7) $display("FAIL rep_mem_addr got=%h want=7", mem_addr); else n_pass++;
   endtask

   task automatic test_reset_midop();
      int c;
      bit acked = 0;
      stall = 1;
      req0 = 1; wr0 = 0; addr0 = 32'd5; data0 = 32'h0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (ack0) acked = 1;
      end
      rst_n = 0;
      #1;
      n_checks++;
      if ({mem_wr, mem_addr, mem_data} !== '0) $display("FAIL midrst_mem got=%b/%h/%h want=0", mem_wr, mem_addr, mem_data);
      else n_pass++;
      req0 = 0;
      @(posedge clk); #1;
      if (ack0) acked = 1;
      @(posedge clk); #1;
      if (ack0) acked = 1;
      n_checks++;
      if (acked) $display("FAIL midrst_ack got=1 want=0"); else n_pass++;
      rst_n = 1;
      stall = 0;
      @(posedge clk); #1;
      do_req(0, 0, 32'd5, 32'h0, c);
      n_checks++;
      if (c !== 3) $display("FAIL midrst_latency got=%0d want=3", c); else n_pass++;
      got = exp_q0.pop_front();
      n_checks++;
      if (rdata0 !== got) $display("FAIL midrst_data got=%h want=%h", rdata0, got); else n_pass++;
   endtask

   task automatic test_timeout();
      int c;
      int err_at = -1;
      int err_cnt = 0;
      bit acked = 0;
      stall = 1;
      req0 = 1; wr0 = 1; addr0 = 32'd20; data0 = 32'h55;
`ifdef RAM_ARB_TIMEOUT_EN
      for (int i = 1; i <= 40 && err_at < 0; i++) begin
         @(posedge clk); #1;
         if (ack0) acked = 1;
         if (err) err_at = i;
      end
      req0 = 0;
      @(posedge clk); #1;
      if (err) err_cnt++;
      n_checks++;
      if (err_at !== 17) $display("FAIL to_err_cycle got=%0d want=17", err_at); else n_pass++;
      n_checks++;
      if (acked || err_cnt != 0) $display("FAIL to_ack_or_long_err got=%0d/%0d want=0/0", acked, err_cnt);
      else n_pass++;
      stall = 0;
      do_req(0, 1, 32'd21, 32'h66, c);
      n_checks++;
      if (c !== 3) $display("FAIL to_recover_latency got=%0d want=3", c); else n_pass++;
`else
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (ack0) acked = 1;
         if (err) err_cnt++;
      end
      n_checks++;
      if (acked || err_cnt != 0) $display("FAIL nowd_stall got=%0d/%0d want=0/0", acked, err_cnt);
      else n_pass++;
      stall = 0;
      c = -1;
      for (int i = 1; i <= 10 && c < 0; i++) begin
         @(posedge clk); #1;
         if (ack0) c = i;
      end
      req0 = 0;
      shadow[20] = 32'h55;
      @(posedge clk); #1;
      n_checks++;
      if (c < 0) $display("FAIL nowd_resume got=none want=ack"); else n_pass++;
      do_req(0, 0, 32'd20, 32'h0, c);
      got = exp_q0.pop_front();
      n_checks++;
      if (rdata0 !== got) $display("FAIL nowd_data got=%h want=%h", rdata0, got); else n_pass++;
`endif
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_contention();
      test_repeat();
      test_reset_midop();
      test_timeout();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
